// File: rtl/memory_if.sv
// Request/response bundle for the single-port RAM: valid/ready handshake,
// request type, address and data in both directions.
interface memory_if #(
    parameter int WIDTH = 32,
    parameter int ADDRE = 8
);
    logic             valid;
    logic             wrdata;
    logic [ADDRE-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ready;

    modport master (
        output valid,
        output wrdata,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  wrdata,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/memory.sv
// Single-port synchronous WIDTH x DEPTH RAM with a one-cycle valid/ready
// handshake; reset clears the whole array and both registered outputs.
module memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDRE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] read_o,
    input  logic [WIDTH-1:0] write_i,
    input  logic             valid_i,
    input  logic             wrdata_i,
    output logic             ready_o,
    input  logic [ADDRE-1:0] addre_i
);

    reg [WIDTH-1:0] mem [0:DEPTH-1];

    // Storage array: cleared on reset, written by accepted write requests.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (valid_i && wrdata_i) begin
            mem[addre_i] <= write_i;
        end else begin
            mem[addre_i] <= mem[addre_i];
        end
    end

    // Read data register: only a read request updates it, writes leave it held.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_o <= '0;
        end else if (valid_i && !wrdata_i) begin
            read_o <= mem[addre_i];
        end else begin
            read_o <= read_o;
        end
    end

    // Handshake register: ready follows valid with one cycle of latency.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_o <= 1'b0;
        end else if (valid_i) begin
            ready_o <= 1'b1;
        end else begin
            ready_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory: a driver pushes expected read_o per request,
// a negedge monitor pops and compares whenever ready_o is high.
module tb_memory;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int ADDRE = 8;

    logic clk;
    logic rst_n;

    memory_if #(.WIDTH(WIDTH), .ADDRE(ADDRE)) bus ();

    memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRE(ADDRE)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .read_o   (bus.rdata),
        .write_i  (bus.wdata),
        .valid_i  (bus.valid),
        .wrdata_i (bus.wrdata),
        .ready_o  (bus.ready),
        .addre_i  (bus.addr)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] model [0:DEPTH-1];
    logic [WIDTH-1:0] last_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pattern(input int a);
        logic [WIDTH-1:0] v;
        v = 32'h12153524 ^ (32'(a) * 32'h01010101);
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected no outstanding request");
            end else begin
                check("read_data", bus.rdata, exp_q.pop_front());
            end
        end
    end

    task automatic issue(input logic we, input logic [ADDRE-1:0] a, input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        bus.valid  = 1'b1;
        bus.wrdata = we;
        bus.addr   = a;
        bus.wdata  = d;
        if (we) begin
            model[a] = d;
        end else begin
            last_rd = model[a];
        end
        exp_q.push_back(last_rd);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.valid  = 1'b0;
        bus.wrdata = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rd = '0;
    endtask

    initial begin
        int bad;
        rst_n      = 1'b0;
        bus.valid  = 1'b0;
        bus.wrdata = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        model_clear();
        #12;
        check("reset_read_o", bus.rdata, 32'h0);
        check("reset_ready_o", {31'h0, bus.ready}, 32'h0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== 32'h0) bad++;
        check("reset_mem_zero", 32'(bad), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Front-door write of every address, then front-door read back.
        for (int a = 0; a < DEPTH; a++) issue(1'b1, 8'(a), pattern(a));
        idle();
        drain();
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut.mem[i] !== pattern(i)) bad++;
        check("backdoor_dump", 32'(bad), 32'h0);
        check("mem0_value", dut.mem[0], 32'h12153524);
        for (int a = 0; a < DEPTH; a++) issue(1'b0, 8'(a), 32'h0);
        idle();
        drain();

        // Idle cycle drops ready on the next edge.
        @(negedge clk);
        check("idle_ready_low", {31'h0, bus.ready}, 32'h0);

        // Backdoor write while idle, then front-door read.
        dut.mem[5] = 32'hDEADBEEF;
        model[5]   = 32'hDEADBEEF;
        issue(1'b0, 8'd5, 32'h0);
        idle();
        drain();
        check("backdoor_read_last", bus.rdata, 32'hDEADBEEF);

        // Valid held three cycles; read then two writes that must hold read_o.
        issue(1'b0, 8'd7, 32'h0);
        issue(1'b1, 8'd7, 32'hCAFEF00D);
        issue(1'b1, 8'd7, 32'hCAFEF00D);
        idle();
        drain();
        check("write_holds_read_o", bus.rdata, pattern(7));
        // Read-after-write in consecutive cycles.
        issue(1'b1, 8'd200, 32'h0BADC0DE);
        issue(1'b0, 8'd200, 32'h0);
        issue(1'b0, 8'd255, 32'h0);
        idle();
        drain();

        // Reset mid-operation drops the in-flight read.
        issue(1'b1, 8'd10, 32'hA5A5A5A5);
        idle();
        drain();
        issue(1'b0, 8'd10, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_read_o", bus.rdata, 32'h0);
        check("midrst_ready_o", {31'h0, bus.ready}, 32'h0);
        exp_q.delete();
        bus.valid = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_mem10", dut.mem[10], 32'h0);
        issue(1'b0, 8'd10, 32'h0);
        idle();
        drain();
        check("midrst_readback", bus.rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
